// File: rtl/network_sched_engine.sv
// network_sched_engine: sequential update engine for a Boolean signalling network.
// It holds the network state, drives it to an external rule block and writes back
// that block's next state, either all elements at once (synchronous mode) or one
// element per cycle in a random visit order (SROr mode), for a requested number of
// rounds.
// Optional feature: define STEADY_STATE_EN to end a run early after the first round
// in which no element changed.
module network_sched_engine #(
  parameter int          RULES   = 61,
  parameter int          ROUND_W = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [ROUND_W-1:0]         num_rounds,
  input  logic [RULES-1:0]           init_state,
  output logic [RULES-1:0]           curr_state,
  input  logic [RULES-1:0]           next_state_in,
  output logic                       busy,
  output logic                       done,
  output logic                       steady,
  output logic [ROUND_W-1:0]         round_count,
  output logic                       upd_valid,
  output logic [$clog2(RULES)-1:0]   upd_idx
);

  localparam int          IW       = $clog2(RULES);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [RULES-1:0]     curr_q, curr_d;
  logic [RULES-1:0]     mask_q, mask_d, mask_set;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [ROUND_W-1:0]   nround_q, nround_d;
  logic                 mode_q, mode_d;
  logic                 steady_q, steady_d;
  logic                 chg_q, chg_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [IW-1:0]        sel;
  logic [IW:0]          pick, idx;
  logic                 round_end, round_chg;

  // Saturating round counter increment.
  function automatic logic [ROUND_W-1:0] sat_inc(input logic [ROUND_W-1:0] v);
    return (v == {ROUND_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // 16-bit Fibonacci LFSR step, taps 15/13/12/10, shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Pick the first unvisited element at or after the LFSR-derived start point.
  always_comb begin
    pick = {1'b0, lfsr_q[IW-1:0]};
    if (pick >= (IW+1)'(RULES)) pick = pick - (IW+1)'(RULES);
    sel = '0;
    idx = '0;
    // Scan from the farthest offset down so the nearest free slot wins.
    for (int off = RULES - 1; off >= 0; off--) begin
      idx = pick + (IW+1)'(off);
      if (idx >= (IW+1)'(RULES)) idx = idx - (IW+1)'(RULES);
      if (!mask_q[idx[IW-1:0]]) sel = idx[IW-1:0];
    end
    mask_set = mask_q | ({{(RULES-1){1'b0}}, 1'b1} << sel);
  end

  // Next-state and update logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    curr_d    = curr_q;
    mask_d    = mask_q;
    round_d   = round_q;
    nround_d  = nround_q;
    mode_d    = mode_q;
    steady_d  = steady_q;
    chg_d     = chg_q;
    lfsr_d    = lfsr_q;
    upd_valid = 1'b0;
    upd_idx   = '0;
    round_end = 1'b0;
    round_chg = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          curr_d   = init_state;
          round_d  = '0;
          steady_d = 1'b0;
          mask_d   = '0;
          chg_d    = 1'b0;
          mode_d   = mode;
          nround_d = num_rounds;
          state_d  = RUN;
        end
      end
      RUN: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (nround_q == '0) begin
          state_d = DONE;
        end else if (!mode_q) begin
          curr_d    = next_state_in;
          round_end = 1'b1;
          round_chg = (next_state_in != curr_q);
        end else begin
          upd_valid   = 1'b1;
          upd_idx     = sel;
          curr_d[sel] = next_state_in[sel];
          round_chg   = chg_q | (next_state_in[sel] != curr_q[sel]);
          chg_d       = round_chg;
          if (mask_set == {RULES{1'b1}}) begin
            mask_d    = '0;
            round_end = 1'b1;
          end else begin
            mask_d    = mask_set;
          end
        end
        if (round_end) begin
          round_d  = sat_inc(round_q);
          steady_d = ~round_chg;
          chg_d    = 1'b0;
          if (({1'b0, round_q} + 1'b1) == {1'b0, nround_q}) state_d = DONE;
`ifdef STEADY_STATE_EN
          if (!round_chg) state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and state registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      curr_q   <= '0;
      mask_q   <= '0;
      round_q  <= '0;
      steady_q <= 1'b0;
      chg_q    <= 1'b0;
      lfsr_q   <= SEED_EFF;
    end else begin
      state_q  <= state_d;
      curr_q   <= curr_d;
      mask_q   <= mask_d;
      round_q  <= round_d;
      steady_q <= steady_d;
      chg_q    <= chg_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Run parameters captured with start; only meaningful while a run is active.
  always_ff @(posedge clk) begin
    mode_q   <= mode_d;
    nround_q <= nround_d;
  end

  assign curr_state  = curr_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign steady      = steady_q;
  assign round_count = round_q;

endmodule

// File: tb/tb_network_sched_engine.sv
// Testbench for network_sched_engine: randomized runs checked against a
// round-level reference model of the scheduling rules.
module tb_network_sched_engine;
  localparam int          RULES   = 5;
  localparam int          ROUND_W = 16;
  localparam int          IW      = $clog2(RULES);
  localparam logic [15:0] SEED    = 16'hACE1;

  logic                 clk = 1'b0;
  logic                 rst, start, mode;
  logic [ROUND_W-1:0]   num_rounds;
  logic [RULES-1:0]     init_state, curr_state, next_state_in;
  logic                 busy, done, steady, upd_valid;
  logic [ROUND_W-1:0]   round_count;
  logic [IW-1:0]        upd_idx;

  int          checks = 0;
  int          errors = 0;
  int          rule_sel = 0;
  logic [15:0] m_lfsr = SEED;

  network_sched_engine #(.RULES(RULES), .ROUND_W(ROUND_W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_rounds(num_rounds),
    .init_state(init_state), .curr_state(curr_state), .next_state_in(next_state_in),
    .busy(busy), .done(done), .steady(steady), .round_count(round_count),
    .upd_valid(upd_valid), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  // Rule block: 0 ring rotate, 1 invert, 2 identity, 3 nonlinear mix.
  function automatic logic [RULES-1:0] rule_fn(input logic [RULES-1:0] s, input int r);
    logic [RULES-1:0] n;
    n = s;
    for (int i = 0; i < RULES; i++) begin
      case (r)
        0:       n[i] = s[(i + RULES - 1) % RULES];
        1:       n[i] = ~s[i];
        2:       n[i] = s[i];
        default: n[i] = s[(i + 1) % RULES] ^ (s[(i + 2) % RULES] & ~s[i]);
      endcase
    end
    return n;
  endfunction

  assign next_state_in = rule_fn(curr_state, rule_sel);

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One complete run from IDLE, checked cycle by cycle against the model.
  task automatic run(input bit md, input int n, input logic [RULES-1:0] init,
                     input int r, input bit hold);
    logic [RULES-1:0] es, nx;
    int  rc, cyc, pick, j, nvis;
    bit  stdy, chg, fin, rend;
    bit  vis[RULES];
    es = init; rc = 0; stdy = 0; chg = 0; fin = 0; cyc = 0; nvis = 0;
    for (int i = 0; i < RULES; i++) vis[i] = 0;
    rule_sel = r; mode = md; num_rounds = ROUND_W'(n); init_state = init; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    while (!fin && cyc < 1000) begin
      rend = 0;
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("state_run", curr_state, es);
      nx = rule_fn(es, r);
      if (n == 0) begin
        check("upd_valid_n0", upd_valid, 0);
        fin = 1;
      end else if (!md) begin
        check("upd_valid_sync", upd_valid, 0);
        chg  = (nx != es);
        es   = nx;
        rend = 1;
      end else begin
        pick = int'(m_lfsr[IW-1:0]);
        if (pick >= RULES) pick -= RULES;
        j = pick;
        while (vis[j]) j = (j + 1) % RULES;
        check("upd_valid_sror", upd_valid, 1);
        check("upd_idx", upd_idx, j);
        if (nx[j] != es[j]) chg = 1;
        es[j] = nx[j];
        vis[j] = 1;
        nvis++;
        if (nvis == RULES) begin
          nvis = 0;
          for (int i = 0; i < RULES; i++) vis[i] = 0;
          rend = 1;
        end
      end
      if (rend) begin
        if (rc < (2 ** ROUND_W) - 1) rc++;
        stdy = !chg;
        chg  = 0;
        if (rc == n) fin = 1;
`ifdef STEADY_STATE_EN
        if (stdy) fin = 1;
`endif
      end
      m_lfsr = lfsr_step(m_lfsr);
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) check("timeout", 0, 1);
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("final_state", curr_state, es);
    check("round_count", round_count, rc);
    check("steady", steady, stdy);
    @(posedge clk); #1;
    check("done_once", done, 0);
    check("busy_idle", busy, 0);
    check("hold_state", curr_state, es);
    check("hold_rounds", round_count, rc);
  endtask

  initial begin
    logic [RULES-1:0] v;
    int exp_rc;
    rst = 1'b1; start = 1'b0; mode = 1'b0; num_rounds = '0; init_state = '0;
    #1;
    check("rst_curr", curr_state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_steady", steady, 0);
    check("rst_rounds", round_count, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_upd_idx", upd_idx, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Synchronous ring rotation.
    run(1'b0, 3, 5'b00001, 0, 1'b0);
    check("ring_state", curr_state, 5'b01000);
    check("ring_rounds", round_count, 3);

    // SROr inversion: two rounds bring the state back.
    run(1'b1, 2, 5'b10110, 1, 1'b0);
    check("inv_state", curr_state, 5'b10110);
    check("inv_rounds", round_count, 2);

    // Identity rule: steady after the first round.
    v = 5'($urandom);
    run(1'b1, 10, v, 2, 1'b0);
`ifdef STEADY_STATE_EN
    exp_rc = 1;
`else
    exp_rc = 10;
`endif
    check("ident_rounds", round_count, exp_rc);
    check("ident_steady", steady, 1);
    check("ident_state", curr_state, v);

    // Zero rounds: no updates, state untouched.
    run(1'b1, 0, 5'b00111, 3, 1'b0);
    check("zero_state", curr_state, 5'b00111);
    check("zero_rounds", round_count, 0);

    // Reset in the middle of an SROr run.
    rule_sel = 1; mode = 1'b1; num_rounds = 16'd5; init_state = 5'b10110; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_curr", curr_state, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rounds", round_count, 0);
    check("abort_upd_valid", upd_valid, 0);
    check("abort_upd_idx", upd_idx, 0);
    @(posedge clk); #1;
    check("abort_no_done", done, 0);
    rst = 1'b0;
    m_lfsr = SEED;
    run(1'b1, 3, 5'($urandom), 3, 1'b0);

    // start held through a run, then a second run straight from IDLE.
    v = 5'($urandom);
    run(1'b0, 2, v, 3, 1'b1);
    run(1'b0, 2, v, 3, 1'b0);
    v = 5'($urandom);
    run(1'b1, 2, v, 0, 1'b1);
    run(1'b1, 2, v, 0, 1'b0);

    // Randomized runs.
    for (int t = 0; t < 14; t++) begin
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 5'($urandom),
          int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
